// File: rtl/mem_access_unit.sv
// Memory access unit: muxes fetch/data addresses, formats stores, extends loads, handshakes with the bus.
// Optional ack watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
    parameter logic [31:0] RESET_INST     = 32'h00000013,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iPC,
    input  logic [31:0] iALUOut,
    input  logic [31:0] iWriteData,
    input  logic        iIorD,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iWriteIR,
    input  logic [2:0]  iFunct3,
    output logic        oBusReq,
    output logic        oBusWe,
    output logic [31:0] oBusAddr,
    output logic [31:0] oBusWData,
    output logic [3:0]  oBusBe,
    input  logic        iBusAck,
    input  logic [31:0] iBusRData,
    output logic [31:0] oInst,
    output logic [31:0] oMDR,
    output logic        oBusy,
    output logic        oDone,
    output logic        oMisalign,
    output logic        oBusErr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, inst_q, inst_d, mdr_q, mdr_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d, fetch_q, fetch_d;
    logic [2:0]  ldop_q, ldop_d;
    logic        done_q, done_d, mis_q, mis_d;

    logic [31:0] req_addr, st_data, ld_ext;
    logic [3:0]  st_be;
    logic        misaligned;
    size_t       size;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Request decode: fetches are always words; store and load width tables differ for 1xx codes.
    always_comb begin
        req_addr = iIorD ? iALUOut : iPC;
        if (!iIorD) begin
            size = SZ_WORD;
        end else if (iMemWrite) begin
            case (iFunct3)
                3'b000:  size = SZ_BYTE;
                3'b001:  size = SZ_HALF;
                default: size = SZ_WORD;
            endcase
        end else begin
            case (iFunct3)
                3'b000, 3'b100: size = SZ_BYTE;
                3'b001, 3'b101: size = SZ_HALF;
                default:        size = SZ_WORD;
            endcase
        end
        misaligned = ((size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                     ((size == SZ_HALF) && req_addr[0]);
        case (size)
            SZ_BYTE: begin
                st_be   = 4'b0001 << req_addr[1:0];
                st_data = {4{iWriteData[7:0]}};
            end
            SZ_HALF: begin
                st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{iWriteData[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = iWriteData;
            end
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = iBusRData[7:0];
            2'd1:    lane_b = iBusRData[15:8];
            2'd2:    lane_b = iBusRData[23:16];
            default: lane_b = iBusRData[31:24];
        endcase
        lane_h = addr_q[1] ? iBusRData[31:16] : iBusRData[15:0];
        case (ldop_q)
            3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  ld_ext = {24'b0, lane_b};
            3'b101:  ld_ext = {16'b0, lane_h};
            default: ld_ext = iBusRData;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        fetch_d = fetch_q;
        ldop_d  = ldop_q;
        inst_d  = inst_q;
        mdr_d   = mdr_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (iMemRead || iMemWrite) begin
                    if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        we_d    = iMemWrite;
                        be_d    = iMemWrite ? st_be : 4'b1111;
                        wdata_d = iMemWrite ? st_data : '0;
                        fetch_d = iWriteIR;
                        ldop_d  = iIorD ? iFunct3 : 3'b010;
                        state_d = S_REQ;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                if (iBusAck) begin
                    if (!we_q) begin
                        if (fetch_q) inst_d = iBusRData;
                        else         mdr_d  = ld_ext;
                    end
                    done_d  = 1'b1;
                    state_d = S_RESP;
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            ldop_q  <= '0;
            inst_q  <= RESET_INST;
            mdr_q   <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            fetch_q <= fetch_d;
            ldop_q  <= ldop_d;
            inst_q  <= inst_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign oBusErr = err_q;
`else
    assign oBusErr = 1'b0;
`endif

    assign oBusReq   = (state_q == S_REQ);
    assign oBusy     = (state_q != S_IDLE);
    assign oBusWe    = we_q;
    assign oBusAddr  = addr_q;
    assign oBusWData = wdata_q;
    assign oBusBe    = be_q;
    assign oInst     = inst_q;
    assign oMDR      = mdr_q;
    assign oDone     = done_q;
    assign oMisalign = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand sequences, randomized model check.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [31:0] iPC, iALUOut, iWriteData, iBusRData;
    logic        iIorD, iMemRead, iMemWrite, iWriteIR, iBusAck;
    logic [2:0]  iFunct3;
    logic        oBusReq, oBusWe, oBusy, oDone, oMisalign, oBusErr;
    logic [31:0] oBusAddr, oBusWData, oInst, oMDR;
    logic [3:0]  oBusBe;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] m_inst, m_mdr;

    mem_access_unit #(
        .RESET_INST    (32'h00000013),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iPC(iPC), .iALUOut(iALUOut), .iWriteData(iWriteData),
        .iIorD(iIorD), .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iWriteIR(iWriteIR),
        .iFunct3(iFunct3), .oBusReq(oBusReq), .oBusWe(oBusWe), .oBusAddr(oBusAddr),
        .oBusWData(oBusWData), .oBusBe(oBusBe), .iBusAck(iBusAck), .iBusRData(iBusRData),
        .oInst(oInst), .oMDR(oMDR), .oBusy(oBusy), .oDone(oDone), .oMisalign(oMisalign),
        .oBusErr(oBusErr)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic        iord;
        logic [31:0] pc, alu, wd;
        logic        rd, wr, wir;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int unsigned dly;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic [31:0] e_inst, e_mdr;
    } vec_t;

    function automatic vec_t mkv(logic iord, logic [31:0] pc, logic [31:0] alu, logic [31:0] wd,
                                 logic rd, logic wr, logic wir, logic [2:0] f3, logic [31:0] rdata,
                                 int unsigned dly, logic [31:0] e_addr, logic e_we, logic [3:0] e_be,
                                 logic [31:0] e_wdata, logic e_mis, logic [31:0] e_inst,
                                 logic [31:0] e_mdr);
        vec_t v;
        v.iord = iord; v.pc = pc; v.alu = alu; v.wd = wd; v.rd = rd; v.wr = wr; v.wir = wir;
        v.f3 = f3; v.rdata = rdata; v.dly = dly; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_mis = e_mis; v.e_inst = e_inst; v.e_mdr = e_mdr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iMemRead = 1'b0; iMemWrite = 1'b0; iWriteIR = 1'b0; iBusAck = 1'b0;
    endtask

    // Transaction-level reference: sizes, lanes and extension from plain arithmetic.
    task automatic model(inout vec_t v);
        int unsigned nb, sh;
        logic [31:0] a, f;
        a = v.iord ? v.alu : v.pc;
        if (!v.iord)    nb = 4;
        else if (v.wr)  nb = (v.f3 == 3'd0) ? 1 : (v.f3 == 3'd1) ? 2 : 4;
        else            nb = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 :
                             (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
        v.e_mis = ((a % nb) != 0);
        v.e_addr = a;
        v.e_we = v.wr;
        sh = 8 * (a % 4);
        if (v.wr) begin
            if (nb == 1)      begin v.e_be = 4'(1 << (a % 4)); v.e_wdata = (v.wd & 32'hFF) * 32'h01010101; end
            else if (nb == 2) begin v.e_be = (a % 4 == 2) ? 4'hC : 4'h3; v.e_wdata = (v.wd & 32'hFFFF) * 32'h00010001; end
            else              begin v.e_be = 4'hF; v.e_wdata = v.wd; end
        end else begin
            v.e_be = 4'hF;
            v.e_wdata = 32'h0;
        end
        if (!v.e_mis && !v.wr) begin
            if (v.wir) m_inst = v.rdata;
            else begin
                f = v.rdata >> sh;
                if (nb == 1) begin
                    f = f & 32'hFF;
                    if (v.f3 == 3'd0 && f >= 32'd128) f = f + 32'hFFFFFF00;
                end else if (nb == 2) begin
                    f = f & 32'hFFFF;
                    if (v.f3 == 3'd1 && f >= 32'd32768) f = f + 32'hFFFF0000;
                end else f = v.rdata;
                m_mdr = f;
            end
        end
        v.e_inst = m_inst;
        v.e_mdr  = m_mdr;
    endtask

    task automatic apply(input vec_t v, input string tag);
        iIorD = v.iord; iPC = v.pc; iALUOut = v.alu; iWriteData = v.wd; iFunct3 = v.f3;
        iMemRead = v.rd; iMemWrite = v.wr; iWriteIR = v.wir;
        cyc();
        iMemRead = 1'b0; iMemWrite = 1'b0; iWriteIR = 1'b0;
        if (v.e_mis) begin
            check({tag, "_mis_pulse"}, 32'(oMisalign), 32'd1);
            check({tag, "_mis_noreq"}, 32'(oBusReq), 32'd0);
            check({tag, "_mis_busy"}, 32'(oBusy), 32'd0);
            cyc();
            check({tag, "_mis_clear"}, 32'(oMisalign), 32'd0);
            check({tag, "_mis_noreq2"}, 32'(oBusReq), 32'd0);
            check({tag, "_mis_inst"}, oInst, v.e_inst);
            check({tag, "_mis_mdr"}, oMDR, v.e_mdr);
            return;
        end
        check({tag, "_nomis"}, 32'(oMisalign), 32'd0);
        check({tag, "_req"}, 32'(oBusReq), 32'd1);
        check({tag, "_addr"}, oBusAddr, v.e_addr);
        check({tag, "_we"}, 32'(oBusWe), 32'(v.e_we));
        check({tag, "_be"}, 32'(oBusBe), 32'(v.e_be));
        check({tag, "_wdata"}, oBusWData, v.e_wdata);
        for (int unsigned i = 0; i < v.dly; i++) begin
            iBusRData = $urandom;
            cyc();
            check({tag, "_req_hold"}, 32'(oBusReq), 32'd1);
            check({tag, "_addr_hold"}, oBusAddr, v.e_addr);
            check({tag, "_done_early"}, 32'(oDone), 32'd0);
        end
        iBusAck = 1'b1; iBusRData = v.rdata;
        cyc();
        iBusAck = 1'b0; iBusRData = $urandom;
        check({tag, "_done"}, 32'(oDone), 32'd1);
        check({tag, "_busy_resp"}, 32'(oBusy), 32'd1);
        check({tag, "_req_drop"}, 32'(oBusReq), 32'd0);
        check({tag, "_inst"}, oInst, v.e_inst);
        check({tag, "_mdr"}, oMDR, v.e_mdr);
        check({tag, "_noerr"}, 32'(oBusErr), 32'd0);
        cyc();
        check({tag, "_done_clr"}, 32'(oDone), 32'd0);
        check({tag, "_idle"}, 32'(oBusy), 32'd0);
    endtask

    vec_t tbl[13];

    initial begin
        vec_t v;
        int unsigned k;
        logic [31:0] a;

        tbl[0]  = mkv(0, 32'h10,  32'h0,   32'h0,        1,0,1, 3'b000, 32'h00A00093, 1, 32'h10,  0, 4'hF, 32'h0,        0, 32'h00A00093, 32'h0);
        tbl[1]  = mkv(1, 32'h0,   32'h103, 32'h0,        1,0,0, 3'b000, 32'h80FF1234, 0, 32'h103, 0, 4'hF, 32'h0,        0, 32'h00A00093, 32'hFFFFFF80);
        tbl[2]  = mkv(1, 32'h0,   32'h103, 32'h0,        1,0,0, 3'b100, 32'h80FF1234, 2, 32'h103, 0, 4'hF, 32'h0,        0, 32'h00A00093, 32'h00000080);
        tbl[3]  = mkv(1, 32'h0,   32'h202, 32'h0000BEEF, 0,1,0, 3'b001, 32'h55555555, 1, 32'h202, 1, 4'hC, 32'hBEEFBEEF, 0, 32'h00A00093, 32'h00000080);
        tbl[4]  = mkv(1, 32'h0,   32'h101, 32'h0,        1,0,0, 3'b010, 32'h0,        0, 32'h0,   0, 4'h0, 32'h0,        1, 32'h00A00093, 32'h00000080);
        tbl[5]  = mkv(1, 32'h0,   32'h100, 32'h12345678, 1,1,0, 3'b010, 32'hAAAAAAAA, 0, 32'h100, 1, 4'hF, 32'h12345678, 0, 32'h00A00093, 32'h00000080);
        tbl[6]  = mkv(1, 32'h0,   32'h102, 32'h0,        1,0,0, 3'b001, 32'h80FF1234, 3, 32'h102, 0, 4'hF, 32'h0,        0, 32'h00A00093, 32'hFFFF80FF);
        tbl[7]  = mkv(1, 32'h0,   32'h102, 32'h0,        1,0,0, 3'b101, 32'h80FF1234, 0, 32'h102, 0, 4'hF, 32'h0,        0, 32'h00A00093, 32'h000080FF);
        tbl[8]  = mkv(1, 32'h0,   32'h201, 32'h000000A5, 0,1,0, 3'b000, 32'h0,        1, 32'h201, 1, 4'h2, 32'hA5A5A5A5, 0, 32'h00A00093, 32'h000080FF);
        tbl[9]  = mkv(1, 32'h0,   32'h203, 32'h0000BEEF, 0,1,0, 3'b001, 32'h0,        0, 32'h0,   0, 4'h0, 32'h0,        1, 32'h00A00093, 32'h000080FF);
        tbl[10] = mkv(1, 32'h0,   32'h204, 32'h0,        1,0,0, 3'b010, 32'hDEADBEEF, 0, 32'h204, 0, 4'hF, 32'h0,        0, 32'h00A00093, 32'hDEADBEEF);
        tbl[11] = mkv(0, 32'h12,  32'h0,   32'h0,        1,0,1, 3'b000, 32'h0,        0, 32'h0,   0, 4'h0, 32'h0,        1, 32'h00A00093, 32'hDEADBEEF);
        tbl[12] = mkv(1, 32'h0,   32'h100, 32'h0,        1,0,0, 3'b000, 32'h0000007F, 0, 32'h100, 0, 4'hF, 32'h0,        0, 32'h00A00093, 32'h0000007F);

        iRst = 1'b1; iPC = '0; iALUOut = '0; iWriteData = '0; iIorD = 1'b0; iFunct3 = '0;
        iBusRData = '0;
        idle_inputs();
        cyc(); cyc();
        check("rst_inst", oInst, 32'h00000013);
        check("rst_mdr", oMDR, 32'h0);
        check("rst_req", 32'(oBusReq), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_status", {28'd0, oDone, oMisalign, oBusErr, oBusWe}, 32'd0);
        check("rst_addr", oBusAddr, 32'h0);
        check("rst_wdata", oBusWData, 32'h0);
        check("rst_be", 32'(oBusBe), 32'd0);
        iRst = 1'b0;
        cyc();

        for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));
        m_inst = tbl[12].e_inst;
        m_mdr  = tbl[12].e_mdr;

        // Ack while idle must not touch IR/MDR.
        iBusAck = 1'b1; iBusRData = 32'hCAFEF00D;
        cyc(); cyc();
        iBusAck = 1'b0;
        check("idle_ack_busy", 32'(oBusy), 32'd0);
        check("idle_ack_done", 32'(oDone), 32'd0);
        check("idle_ack_mdr", oMDR, m_mdr);
        check("idle_ack_inst", oInst, m_inst);

        // Strobes during REQ and RESP are ignored.
        iIorD = 1'b1; iALUOut = 32'h300; iFunct3 = 3'b010; iMemRead = 1'b1;
        cyc();
        iMemRead = 1'b0;
        check("busy_req", 32'(oBusReq), 32'd1);
        iMemWrite = 1'b1; iALUOut = 32'h400;
        cyc();
        iMemWrite = 1'b0;
        check("busy_ign_addr", oBusAddr, 32'h300);
        check("busy_ign_we", 32'(oBusWe), 32'd0);
        iBusAck = 1'b1; iBusRData = 32'h11223344;
        cyc();
        iBusAck = 1'b0;
        check("busy_done", 32'(oDone), 32'd1);
        check("busy_mdr", oMDR, 32'h11223344);
        m_mdr = 32'h11223344;
        iMemRead = 1'b1; iALUOut = 32'h500;
        cyc();
        iMemRead = 1'b0;
        check("resp_ign_busy", 32'(oBusy), 32'd0);
        check("resp_ign_req", 32'(oBusReq), 32'd0);

        // Long wait without ack.
        iIorD = 1'b1; iALUOut = 32'h600; iFunct3 = 3'b010; iMemRead = 1'b1;
        cyc();
        iMemRead = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        for (int unsigned i = 0; i < TO; i++) begin
            check("to_req", 32'(oBusReq), 32'd1);
            check("to_noerr", 32'(oBusErr), 32'd0);
            cyc();
        end
        check("to_err", 32'(oBusErr), 32'd1);
        check("to_busy", 32'(oBusy), 32'd0);
        check("to_req_drop", 32'(oBusReq), 32'd0);
        check("to_mdr", oMDR, m_mdr);
        cyc();
        check("to_err_clr", 32'(oBusErr), 32'd0);
`else
        for (int i = 0; i < 70; i++) cyc();
        check("wait_req", 32'(oBusReq), 32'd1);
        check("wait_noerr", 32'(oBusErr), 32'd0);
        iBusAck = 1'b1; iBusRData = 32'h0BADF00D;
        cyc();
        iBusAck = 1'b0;
        check("wait_mdr", oMDR, 32'h0BADF00D);
        m_mdr = 32'h0BADF00D;
        cyc();
`endif

        // Reset mid-REQ with ack in the same cycle.
        iIorD = 1'b0; iPC = 32'h40; iMemRead = 1'b1; iWriteIR = 1'b1;
        cyc();
        iMemRead = 1'b0; iWriteIR = 1'b0;
        check("rstmid_req", 32'(oBusReq), 32'd1);
        iRst = 1'b1; iBusAck = 1'b1; iBusRData = 32'hFFFFFFFF;
        cyc();
        iRst = 1'b0; iBusAck = 1'b0;
        check("rstmid_inst", oInst, 32'h00000013);
        check("rstmid_mdr", oMDR, 32'h0);
        check("rstmid_req_drop", 32'(oBusReq), 32'd0);
        check("rstmid_busy", 32'(oBusy), 32'd0);
        check("rstmid_done", 32'(oDone), 32'd0);
        m_inst = 32'h00000013;
        m_mdr  = 32'h0;

        for (int n = 0; n < 300; n++) begin
            v.iord = ($urandom_range(0, 3) != 0);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
            v.pc = a; v.alu = a;
            v.wd = $urandom;
            k = $urandom_range(1, 3);
            v.rd = k[0]; v.wr = k[1];
            v.wir = ($urandom_range(0, 1) == 1);
            v.f3 = 3'($urandom_range(0, 7));
            v.rdata = $urandom;
            v.dly = $urandom_range(0, 3);
            model(v);
            apply(v, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter RESET_INST, default 32'h00000013 (NOP), SHALL be the instruction register value after reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, SHALL be the ack watchdog limit, used only when MEM_ACCESS_TIMEOUT_EN is defined.
REQ-003 iClk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 iRst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 iPC  in  32  SHALL be the fetch address; iALUOut  in  32  SHALL be the data address.
REQ-006 iWriteData  in  32  SHALL be the store data (rs2).
REQ-007 iIorD  in  1  SHALL select the address: 0 = iPC, 1 = iALUOut.
REQ-008 iMemRead  in  1, iMemWrite  in  1, iWriteIR  in  1  SHALL be the control-FSM access strobes.
REQ-009 iFunct3  in  3  SHALL be the load/store width code; it is ignored when iIorD=0.
REQ-010 oBusReq  out  1, oBusWe  out  1, oBusAddr  out  32, oBusWData  out  32, oBusBe  out  4  SHALL form the memory request.
REQ-011 iBusAck  in  1, iBusRData  in  32  SHALL form the memory response.
REQ-012 oInst  out  32  SHALL be the instruction register (IR); oMDR  out  32  SHALL be the memory data register.
REQ-013 oBusy, oDone, oMisalign, oBusErr  out  1 each  SHALL be the status outputs to the control FSM.

Function
REQ-014 The FSM SHALL have three states: IDLE, REQ and RESP; oBusy SHALL be high whenever the state is not IDLE.
REQ-015 IDLE, on an aligned iMemRead or iMemWrite: the unit SHALL register the address, write enable, oBusWData, oBusBe and a fetch flag (iWriteIR), then go to REQ.
REQ-016 If iMemRead and iMemWrite are both high in IDLE, the write SHALL win and the read SHALL be dropped.
REQ-017 REQ: oBusReq SHALL be 1, and all bus outputs SHALL stay stable until the cycle in which iBusAck=1.
REQ-018 On ack, read with fetch flag set: oInst SHALL load iBusRData.
REQ-019 On ack, read with fetch flag clear: oMDR SHALL load the extended data; the state SHALL then become RESP.
REQ-020 RESP SHALL last exactly 1 cycle with oDone=1, then return to IDLE.
REQ-021 Latency: strobe sampled at edge N, oBusReq high from N+1, ack at edge N+k, oInst/oMDR valid and oDone=1 in the cycle after N+k (minimum 3 cycles, strobe to done).
REQ-022 Store encoding by iFunct3:
- 000 (SB): oBusBe = 1 << addr[1:0], byte replicated x4.
- 001 (SH): oBusBe = 0011 or 1100 by addr[1], half-word replicated x2.
- Other codes: oBusBe = 1111, full word.
REQ-023 Load extension by iFunct3: 000 LB sign-extend, 001 LH sign-extend, 100 LBU zero-extend, 101 LHU zero-extend, any other code word; the lane is selected by addr[1:0].
REQ-024 Reads SHALL drive oBusBe = 1111 and oBusWData = 0; fetches SHALL always be word accesses.
REQ-025 Misalignment (word with addr[1:0] != 0, half with addr[0] != 0) SHALL produce no bus request, a 1-cycle oMisalign pulse, unchanged IR/MDR, and the FSM staying in IDLE.
REQ-026 Strobes while oBusy=1 SHALL be ignored; iBusAck in IDLE or RESP SHALL be ignored.
REQ-027 oDone, oMisalign and oBusErr SHALL be registered single-cycle pulses.

Reset
REQ-028 iRst=1 SHALL set: state IDLE, oInst=RESET_INST, oMDR=0, and all bus outputs and status pulses to 0, at the next edge.
REQ-029 Reset mid-transaction SHALL drop oBusReq at that edge, with no IR/MDR update even if iBusAck is high in the same cycle.

Configuration
REQ-030 With MEM_ACCESS_TIMEOUT_EN defined, a counter SHALL clear on entering REQ and increment each REQ cycle without ack.
REQ-031 With MEM_ACCESS_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the unit SHALL abort: oBusReq drops, oBusErr pulses 1 cycle, IR/MDR are unchanged, and the state returns to IDLE.
REQ-032 Without MEM_ACCESS_TIMEOUT_EN, REQ SHALL wait indefinitely, no counter logic SHALL exist, and oBusErr SHALL be constant 0.

Verification
REQ-033 Fetch: iIorD=0, iPC=0x00000010, iMemRead=1, iWriteIR=1; ack 2 cycles later with 0x00A00093 -> oBusAddr=0x10, oInst=0x00A00093, oDone pulse, oMDR unchanged.
REQ-034 LB: iALUOut=0x103, iFunct3=000, iBusRData=0x80FF1234 -> oMDR=0xFFFFFF80; with LBU (iFunct3=100) -> oMDR=0x00000080.
REQ-035 SH: iALUOut=0x202, iWriteData=0x0000BEEF, iMemWrite=1 -> oBusBe=1100, oBusWData=0xBEEFBEEF, oBusWe=1.
REQ-036 Misaligned: LW at 0x101 -> oMisalign 1-cycle pulse, oBusReq stays 0; simultaneous read+write at 0x100 -> oBusWe=1.
REQ-037 Reset mid-REQ with iBusAck=1 in the same cycle -> oInst=0x00000013, oBusReq=0 next cycle.
REQ-038 With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> oBusErr pulses once and oBusy falls at the next edge.
